// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serialises single accesses from two requesters onto one memory
// port, alternating on ties and answering with an error if memory never completes.

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 8
`endif
`ifndef MEM_WORD_SIZE
`define MEM_WORD_SIZE 8
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_W  = `MEM_ADDR_SIZE,
    parameter int unsigned DATA_W  = `MEM_WORD_SIZE,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              arbBusy,
    output logic              memReq,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    input  logic              memBusy,
    input  logic [DATA_W-1:0] memDataOut
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              port_q, port_d;
    logic              last_grant_q, last_grant_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   cnt_inc;
    logic              timed_out;
    logic              grant;

    assign cnt_inc   = cnt_q + CntW'(1);
    assign timed_out = (cnt_inc == CntW'(TIMEOUT));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        wr_d         = wr_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        // On a tie, the port that was not served last wins.
        grant        = (req0 && req1) ? ~last_grant_q : req1;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d      = StIssue;
                    addr_d       = grant ? addr1 : addr0;
                    wdata_d      = grant ? wdata1 : wdata0;
                    wr_d         = grant ? wr1 : wr0;
                    port_d       = grant;
                    last_grant_d = grant;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                cnt_d = cnt_inc;
                if (timed_out) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (memBusy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_inc;
                // A completion seen on the last allowed cycle still counts as success.
                if (!memBusy) begin
                    state_d = StResp;
                    if (!wr_q) begin
                        rdata_d = memDataOut;
                    end
                end else if (timed_out) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            wr_q         <= 1'b0;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            wr_q         <= wr_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign arbBusy   = (state_q != StIdle);
    assign memReq    = (state_q == StIssue);
    assign memWr     = wr_q;
    assign memAddr   = addr_q;
    assign memDataIn = wdata_q;
    assign ack0      = (state_q == StResp) && !port_q;
    assign ack1      = (state_q == StResp) && port_q;
    assign err0      = ack0 && err_q;
    assign err1      = ack1 && err_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model with variable latency, per-port requester
// drivers and a monitor that pops expected completions as acks appear.

module tb_mem_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1, arbBusy, memReq, memWr;
    logic [DW-1:0] rdata, memDataIn;
    logic [AW-1:0] memAddr;
    logic          memBusy = 1'b0;
    logic [DW-1:0] memDataOut = '0;

    // Second instance with a short timeout and a hand-driven memory.
    logic          t_req0 = 1'b0, t_wr0 = 1'b0, t_memBusy = 1'b0;
    logic [AW-1:0] t_addr0 = '0;
    logic          t_ack0, t_ack1, t_err0, t_err1, t_busy, t_memReq, t_memWr;
    logic [DW-1:0] t_rdata, t_memDataIn;
    logic [AW-1:0] t_memAddr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .arbBusy(arbBusy), .memReq(memReq), .memWr(memWr), .memAddr(memAddr),
        .memDataIn(memDataIn), .memBusy(memBusy), .memDataOut(memDataOut)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut_to (
        .clk(clk), .reset(reset),
        .req0(t_req0), .req1(1'b0), .wr0(t_wr0), .wr1(1'b0),
        .addr0(t_addr0), .addr1(8'h00), .wdata0(8'h00), .wdata1(8'h00),
        .ack0(t_ack0), .ack1(t_ack1), .err0(t_err0), .err1(t_err1), .rdata(t_rdata),
        .arbBusy(t_busy), .memReq(t_memReq), .memWr(t_memWr), .memAddr(t_memAddr),
        .memDataIn(t_memDataIn), .memBusy(t_memBusy), .memDataOut(8'hFF)
    );

    typedef struct {
        logic          port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    exp_t          exp_q[$];
    txn_t          pend0[$], pend1[$];
    logic [DW-1:0] model_mem[256];
    logic [DW-1:0] mem[256];
    logic [DW-1:0] rdata_reg = '0;
    int            mem_lat = 1;
    int            n_tests = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Expected results are queued in the order the arbiter must grant them.
    task automatic enqueue(input logic port, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        exp_t e;
        txn_t t;
        if (wr) model_mem[addr] = wdata;
        else rdata_reg = model_mem[addr];
        e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata_reg;
        exp_q.push_back(e);
        t.wr = wr; t.addr = addr; t.wdata = wdata;
        if (port) pend1.push_back(t);
        else pend0.push_back(t);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) break;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            mem[i] = '0;
        end
    end

    // Requesters: drop req on the ack cycle, renew from the pending list one cycle later.
    txn_t drv_t;
    initial forever begin
        @(posedge clk);
        #1;
        if (ack0) req0 = 1'b0;
        else if (!req0 && pend0.size() > 0) begin
            drv_t = pend0.pop_front();
            wr0 = drv_t.wr; addr0 = drv_t.addr; wdata0 = drv_t.wdata; req0 = 1'b1;
        end
        if (ack1) req1 = 1'b0;
        else if (!req1 && pend1.size() > 0) begin
            drv_t = pend1.pop_front();
            wr1 = drv_t.wr; addr1 = drv_t.addr; wdata1 = drv_t.wdata; req1 = 1'b1;
        end
    end

    // Memory: busy rises the cycle after memReq and stays high for mem_lat cycles.
    logic [AW-1:0] mem_a;
    initial forever begin
        @(posedge clk);
        #1;
        if (!reset && memReq) begin
            mem_a = memAddr;
            if (memWr) mem[mem_a] = memDataIn;
            @(posedge clk);
            #3 memBusy = 1'b1;
            repeat (mem_lat) @(posedge clk);
            #3 memBusy = 1'b0;
            memDataOut = mem[mem_a];
        end
    end

    int   req_cnt = 0, busy_cyc = 0, last_lat = 0;
    logic busy_seen = 1'b0, prev_memreq = 1'b0;
    exp_t mon_e;
    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            req_cnt = 0; busy_cyc = 0; busy_seen = 1'b0; prev_memreq = 1'b0;
        end else begin
            if (memReq) begin
                check("memreq_one_cycle", 32'(prev_memreq), 0);
                req_cnt++;
                busy_seen = 1'b0;
                if (exp_q.size() > 0) begin
                    check("issue_addr", 32'(memAddr), 32'(exp_q[0].addr));
                    check("issue_wdata", 32'(memDataIn), 32'(exp_q[0].wdata));
                    check("issue_wr", 32'(memWr), 32'(exp_q[0].wr));
                end
            end else if (memBusy && req_cnt > 0) begin
                busy_seen = 1'b1;
            end
            if (arbBusy) busy_cyc++;
            if (arbBusy && req_cnt > 0 && exp_q.size() > 0)
                check("addr_stable", 32'(memAddr), 32'(exp_q[0].addr));
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack0 | ack1), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_port", 32'(ack1), 32'(mon_e.port));
                    check("ack_other", 32'(mon_e.port ? ack0 : ack1), 0);
                    check("ack_err", 32'(err0 | err1), 0);
                    check("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
                    check("memreq_per_grant", 32'(req_cnt), 1);
                    check("busy_then_low", 32'(busy_seen && !memBusy), 1);
                end
                last_lat = busy_cyc;
                req_cnt = 0; busy_cyc = 0; busy_seen = 1'b0;
            end
            prev_memreq = memReq;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    int n;
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(arbBusy), 0);
        check("rst_memreq", 32'(memReq), 0);
        check("rst_memwr", 32'(memWr), 0);
        check("rst_ack", 32'({ack1, ack0}), 0);
        check("rst_err", 32'({err1, err0}), 0);
        check("rst_addr", 32'(memAddr), 0);
        check("rst_wdata", 32'(memDataIn), 0);
        check("rst_rdata", 32'(rdata), 0);
        #2 reset = 1'b0;

        // Single write then read-back at minimum memory latency.
        @(posedge clk); #2;
        mem_lat = 1;
        enqueue(1'b0, 1'b1, 8'd3, 8'hA5);
        wait_drain(50);
        check("turnaround_wr", 32'(last_lat), 4);
        enqueue(1'b1, 1'b0, 8'd3, 8'h00);
        wait_drain(50);
        check("turnaround_rd", 32'(last_lat), 4);

        // Random latencies, ports and operations, one at a time.
        for (int i = 0; i < 12; i++) begin
            mem_lat = $urandom_range(1, 20);
            enqueue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 15)), 8'($urandom));
            wait_drain(100);
        end

        // Abandon a port-0 read in WAIT_DONE with an asynchronous reset.
        mem_lat = 10;
        wr0 = 1'b0; addr0 = 8'd5; req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (memBusy) break;
        end
        check("mid_busy_seen", 32'(memBusy), 1);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(arbBusy), 0);
        check("mid_rst_memreq", 32'(memReq), 0);
        check("mid_rst_ack", 32'({ack1, ack0}), 0);
        check("mid_rst_addr", 32'(memAddr), 0);
        check("mid_rst_rdata", 32'(rdata), 0);
        req0 = 1'b0;
        rdata_reg = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        repeat (15) @(posedge clk);
        #2;

        // Ties with renewed requests: port 0 first after reset, then strict alternation.
        mem_lat = 1;
        for (int i = 0; i < 4; i++) begin
            enqueue(1'b0, 1'b1, 8'(8'd8 + 8'(i)), 8'(8'h30 + 8'(i)));
            enqueue(1'b1, 1'b0, 8'(8'd8 + 8'(i)), 8'h00);
        end
        wait_drain(200);

        // Timeout instance: one good read of 0xFF, then a read that never completes.
        t_wr0 = 1'b0; t_addr0 = 8'd7; t_req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (t_memReq) break;
        end
        check("to_issue", 32'(t_memReq), 1);
        check("to_issue_addr", 32'(t_memAddr), 7);
        @(posedge clk); #3 t_memBusy = 1'b1;
        @(posedge clk); #3 t_memBusy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (t_ack0) break;
        end
        check("to_ok_ack", 32'(t_ack0), 1);
        check("to_ok_err", 32'(t_err0), 0);
        check("to_ok_rdata", 32'(t_rdata), 32'h0FF);
        t_req0 = 1'b0;
        @(posedge clk); #2;
        t_req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (t_memReq) break;
        end
        check("to_issue2", 32'(t_memReq), 1);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            n++;
            if (t_ack0) break;
        end
        check("to_ack", 32'(t_ack0), 1);
        check("to_within_10", 32'(n <= 10), 1);
        check("to_err", 32'(t_err0), 1);
        check("to_rdata", 32'(t_rdata), 0);
        check("to_port1", 32'({t_ack1, t_err1}), 0);
        check("to_busy", 32'(t_busy), 1);
        check("to_wr", 32'({t_memWr, t_memDataIn}), 0);
        t_req0 = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
